// File: rtl/nvdla_mcif_pkg.sv
// Shared MCIF definitions: read-client indices, read request payload layout
// and the credit granted to a client whose weight is programmed to zero.
package nvdla_mcif_pkg;

  localparam int NUM_RD_CLT  = 12;
  localparam int RD_CID_W    = 4;
  localparam int PD_ADDR_LSB = 0;
  localparam int PD_ADDR_W   = 64;
  localparam int PD_SIZE_LSB = PD_ADDR_LSB + PD_ADDR_W;
  localparam int PD_SIZE_W   = 15;
  localparam int RD_PD_W     = PD_SIZE_LSB + PD_SIZE_W;

  localparam logic [7:0] WT_ZERO_CREDIT = 8'd1;

  typedef enum logic [RD_CID_W-1:0] {
    CLT_BDMA     = 4'd0,
    CLT_SDP      = 4'd1,
    CLT_PDP      = 4'd2,
    CLT_CDP      = 4'd3,
    CLT_SDP_B    = 4'd4,
    CLT_SDP_N    = 4'd5,
    CLT_SDP_E    = 4'd6,
    CLT_CDMA_DAT = 4'd7,
    CLT_CDMA_WT  = 4'd8,
    CLT_RBK      = 4'd9,
    CLT_RSV_0    = 4'd10,
    CLT_RSV_1    = 4'd11
  } rd_clt_e;

  // A zero weight still earns one grant per round so no client can starve.
  function automatic logic [7:0] wt2credit(input logic [7:0] wt);
    return (wt == 8'd0) ? WT_ZERO_CREDIT : wt;
  endfunction

endpackage

// File: rtl/nvdla_mcif_rd_wrr_arb_if.sv
// Read-request handshake bundle: DMA client requests in, arbitrated request out.
interface nvdla_mcif_rd_wrr_arb_if
  import nvdla_mcif_pkg::*;
#(
  parameter int NUM_CLT = NUM_RD_CLT,
  parameter int PD_W    = RD_PD_W,
  parameter int CID_W   = RD_CID_W
);

  logic [NUM_CLT-1:0]      clt_req_valid;
  logic [NUM_CLT-1:0]      clt_req_ready;
  logic [NUM_CLT*PD_W-1:0] clt_req_pd;
  logic                    arb_req_valid;
  logic                    arb_req_ready;
  logic [PD_W-1:0]         arb_req_pd;
  logic [CID_W-1:0]        arb_req_cid;

  modport master (
    input  clt_req_valid, clt_req_pd, arb_req_ready,
    output clt_req_ready, arb_req_valid, arb_req_pd, arb_req_cid
  );

  modport slave (
    output clt_req_valid, clt_req_pd, arb_req_ready,
    input  clt_req_ready, arb_req_valid, arb_req_pd, arb_req_cid
  );

endinterface

// File: rtl/nvdla_mcif_rr_pick.sv
// Circular priority search: first eligible client at or after the rr pointer.
module nvdla_mcif_rr_pick #(
  parameter int NUM_CLT = 12,
  parameter int CID_W   = 4
) (
  input  logic [NUM_CLT-1:0] eligible,
  input  logic [CID_W-1:0]   rr_ptr,
  output logic [NUM_CLT-1:0] grant_oh,
  output logic [CID_W-1:0]   grant_idx,
  output logic               grant_vld
);

  always_comb begin
    logic [CID_W:0] cand;
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CLT; k++) begin
      cand = {1'b0, rr_ptr} + (CID_W+1)'(k);
      if (cand >= (CID_W+1)'(NUM_CLT)) cand = cand - (CID_W+1)'(NUM_CLT);
      if (!grant_vld && eligible[cand[CID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CID_W-1:0];
      end
    end
    grant_oh[grant_idx] = grant_vld;
  end

endmodule

// File: rtl/nvdla_mcif_rd_wrr_arb.sv
// Weighted round-robin arbiter for MCIF read requests: per-client credit rounds,
// an outstanding-read limit and a single registered output stage.
module nvdla_mcif_rd_wrr_arb
  import nvdla_mcif_pkg::*;
#(
  parameter int NUM_CLT = NUM_RD_CLT,
  parameter int PD_W    = RD_PD_W,
  parameter int CID_W   = RD_CID_W
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  nvdla_mcif_rd_wrr_arb_if.master rd_if,
  input  logic [NUM_CLT*8-1:0]   reg2dp_rd_weight,
  input  logic [7:0]             reg2dp_rd_os_cnt,
  input  logic                   rd_done,
  output logic                   arb_idle
);

  logic [7:0]       credit_q [NUM_CLT];
  logic [7:0]       credit_d [NUM_CLT];
  logic [CID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             hold_q, hold_d;
  logic [8:0]       os_cnt_q, os_cnt_d;
  logic             arb_req_valid_q, arb_req_valid_d;
  logic [PD_W-1:0]  arb_req_pd_q, arb_req_pd_d;
  logic [CID_W-1:0] arb_req_cid_q, arb_req_cid_d;
  logic             arb_idle_q, arb_idle_d;

  logic [NUM_CLT-1:0] eligible, grant_oh;
  logic [CID_W-1:0]   grant_idx;
  logic               grant_vld, can_load, os_ok, load, reload, grant_last;
  logic [PD_W-1:0]    grant_pd;

  function automatic logic [CID_W-1:0] idx_inc(input logic [CID_W-1:0] idx);
    return (idx == CID_W'(NUM_CLT-1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CLT; i++)
      eligible[i] = rd_if.clt_req_valid[i] & (credit_q[i] != 8'd0);
  end

  nvdla_mcif_rr_pick #(.NUM_CLT(NUM_CLT), .CID_W(CID_W)) u_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign can_load = ~arb_req_valid_q | rd_if.arb_req_ready;
  assign os_ok    = os_cnt_q < ({1'b0, reg2dp_rd_os_cnt} + 9'd1);
  assign load     = can_load & os_ok & grant_vld;
  assign reload   = ~(|eligible) & (|rd_if.clt_req_valid);

  always_comb begin
    grant_pd   = '0;
    grant_last = 1'b0;
    for (int i = 0; i < NUM_CLT; i++) begin
      grant_pd   |= rd_if.clt_req_pd[i*PD_W +: PD_W] & {PD_W{grant_oh[i]}};
      grant_last |= grant_oh[i] & (credit_q[i] == 8'd1);
    end
  end

  always_comb begin
    credit_d        = credit_q;
    rr_ptr_d        = rr_ptr_q;
    hold_d          = hold_q;
    arb_req_valid_d = arb_req_valid_q & ~rd_if.arb_req_ready;
    arb_req_pd_d    = arb_req_pd_q;
    arb_req_cid_d   = arb_req_cid_q;
    os_cnt_d        = os_cnt_q;
    if (reload) begin
      for (int i = 0; i < NUM_CLT; i++)
        credit_d[i] = wt2credit(reg2dp_rd_weight[i*8 +: 8]);
    end
    if (load) begin
      for (int i = 0; i < NUM_CLT; i++)
        if (grant_oh[i]) credit_d[i] = credit_q[i] - 8'd1;
      arb_req_valid_d = 1'b1;
      arb_req_pd_d    = grant_pd;
      arb_req_cid_d   = grant_idx;
      rr_ptr_d        = grant_last ? idx_inc(grant_idx) : rr_ptr_q;
      hold_d          = ~grant_last;
    end else if (hold_q && !rd_if.clt_req_valid[arb_req_cid_q]) begin
      // last granted client left with credit: stop favouring it
      rr_ptr_d = idx_inc(arb_req_cid_q);
      hold_d   = 1'b0;
    end
    if (load && !rd_done)
      os_cnt_d = os_cnt_q + 9'd1;
    else if (!load && rd_done && os_cnt_q != 9'd0)
      os_cnt_d = os_cnt_q - 9'd1;
  end

  assign arb_idle_d = ~arb_req_valid_q & (os_cnt_q == 9'd0) & ~(|rd_if.clt_req_valid);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < NUM_CLT; i++) credit_q[i] <= 8'd0;
      rr_ptr_q        <= '0;
      hold_q          <= 1'b0;
      os_cnt_q        <= 9'd0;
      arb_req_valid_q <= 1'b0;
      arb_req_pd_q    <= '0;
      arb_req_cid_q   <= '0;
      arb_idle_q      <= 1'b1;
    end else begin
      credit_q        <= credit_d;
      rr_ptr_q        <= rr_ptr_d;
      hold_q          <= hold_d;
      os_cnt_q        <= os_cnt_d;
      arb_req_valid_q <= arb_req_valid_d;
      arb_req_pd_q    <= arb_req_pd_d;
      arb_req_cid_q   <= arb_req_cid_d;
      arb_idle_q      <= arb_idle_d;
    end
  end

  assign rd_if.clt_req_ready = grant_oh & {NUM_CLT{load}};
  assign rd_if.arb_req_valid = arb_req_valid_q;
  assign rd_if.arb_req_pd    = arb_req_pd_q;
  assign rd_if.arb_req_cid   = arb_req_cid_q;
  assign arb_idle            = arb_idle_q;

`ifndef SYNTHESIS
  always @(posedge nvdla_core_clk)
    if (nvdla_core_rstn)
      assert (!(rd_done && os_cnt_q == 9'd0)) else $error("rd_done with no read outstanding");
`endif

endmodule

// File: doc/nvdla_mcif_rd_wrr_arb.md
Name: nvdla_mcif_rd_wrr_arb

Overview:
- Weighted round-robin read-request arbiter for the MCIF read path.
- Consumes the static configuration produced by the MCIF CSB register block: the 12 per-client read weights and the read outstanding count.
- Selects one DMA client read request per cycle, enforces the outstanding-transaction limit, and forwards a registered request with its client ID to the AXI read-request formatter.
- Returns an idle indication that feeds the register block's idle input.

Parameters:
- NUM_CLT, 12, number of read clients; index order 0..11 = bdma, sdp, pdp, cdp, sdp_b, sdp_n, sdp_e, cdma_dat, cdma_wt, rbk, rsv_0, rsv_1.
- PD_W, 79, client request payload width ({size[14:0], addr[63:0]}).
- CID_W, 4, client ID width; must satisfy 2^CID_W >= NUM_CLT.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- clt_req_valid  in  NUM_CLT  per-client request valid.
- clt_req_ready  out  NUM_CLT  per-client accept, one-hot or zero.
- clt_req_pd  in  NUM_CLT*PD_W  client payloads, client i at [i*PD_W +: PD_W].
- reg2dp_rd_weight  in  NUM_CLT*8  weights, client i at [i*8 +: 8].
- reg2dp_rd_os_cnt  in  8  outstanding limit; maximum in flight = value+1.
- rd_done  in  1  one-cycle pulse, one read transaction fully returned.
- arb_req_valid  out  1  registered request valid.
- arb_req_ready  in  1  downstream accept.
- arb_req_pd  out  PD_W  granted payload.
- arb_req_cid  out  CID_W  granted client index.
- arb_idle  out  1  high when no request is in flight, staged or pending.

Behaviour:
- Reset values: arb_req_valid=0, arb_req_pd=0, arb_req_cid=0, clt_req_ready=0 (combinational; follows from empty state), all credits=0, os counter=0, rr pointer=0, arb_idle=1.
- Output stage: single register.
  - can_load = !arb_req_valid | arb_req_ready.
  - Loads only when can_load & os_ok & a grant exists.
  - Holds valid, pd and cid stable until accepted. Never drops a request.
- os_ok = (os_cnt < reg2dp_rd_os_cnt + 1). os_cnt is 9 bits wide.
  - Increments on load.
  - Decrements on rd_done.
  - Simultaneous load and rd_done: os_cnt unchanged.
  - rd_done while os_cnt==0 is illegal: counter saturates at 0, assertion fires.
- Latency: client valid to arb_req_valid is 1 cycle when the output stage is free and os_ok holds.
- Credit counters, 8 bits per client.
  - Eligible client = clt_req_valid[i] & (credit[i] != 0).
  - Grant goes to the first eligible client at or after the rr pointer (circular search).
  - clt_req_ready[grant] = load. Payload is captured in the same cycle.
  - On load: credit[grant] decrements.
  - If the granted credit becomes 0, or the client drops valid after a load, rr pointer = grant+1 (wrap from NUM_CLT-1 to 0). Otherwise the pointer stays, so a client gets consecutive grants.
- Reload: when no client is eligible but at least one valid exists, all credits are loaded from the weights in that cycle. No grant occurs that cycle, which costs one bubble.
  - Weight 0 loads credit 1, so no client starves.
  - Weights are sampled only at reload. A CSB write mid-round takes effect at the next reload.
- Client valid deasserting while credit remains: credit is kept; the client is skipped by the search.
- os limit reached: no grant, no credit change, pointer held.
- arb_idle = !arb_req_valid & (os_cnt==0) & !(|clt_req_valid). Registered, 1-cycle delay.
- Asynchronous reset mid-transfer: all state clears immediately. Downstream must also be in reset.

Decomposition:
- Shared package nvdla_mcif_pkg holds:
  - client index constants (CLT_BDMA=0 … CLT_RSV_1=11),
  - NUM_RD_CLT,
  - the PD_W field offsets,
  - the weight-zero-to-1 rule constant.
- One sub-module, nvdla_mcif_rr_pick: combinational circular priority search giving a one-hot grant and an encoded index, from the eligible vector and the rr pointer.

Test Plan:
- Weights 3 (bdma) and 1 (sdp), others 0, both valid continuously, arb_req_ready=1, os_cnt=255 → cid pattern 0,0,0,1, then a reload bubble, repeating.
- reg2dp_rd_os_cnt=1, bdma always valid, rd_done never pulsed → exactly 2 requests issued, then stall. One rd_done pulse → exactly 1 more request issues on the next cycle.
- arb_req_ready held 0 for 5 cycles with a request staged → arb_req_valid, pd and cid stable throughout; no clt_req_ready asserted; credit unchanged.
- All 12 clients valid with weight 0 → round-robin order 0..11, one grant each, reload bubble, repeat.
- Weights changed from 4 to 1 mid-round → current round completes at 4. The next round uses 1.
- Load and rd_done in the same cycle with os_cnt=3 → os_cnt stays 3. arb_idle rises 1 cycle after the final rd_done with no valids present.
